// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Upstream fetch stage of the rysy core. Owns the program counter and the
// instruction register, applies the controller's pc_sel / inst_sel choices
// every cycle, exposes the decoded instruction fields, and keeps a count of
// retired (non-bubble) instructions.
//
// Ports:
//   clk         clock
//   rst         synchronous active-high reset (wins over stall)
//   stall       freeze pc, inst, bubble, ill_inst and instret this cycle
//   pc_sel      next-PC select: 0=+4, 1=-4, 2=ALU target, 3=hold
//   inst_sel    IR load select: 0=memory, 1=NOP bubble, 2/3=hold
//   alu_out     jump/branch target (bit 0 is forced to zero)
//   imem_rdata  instruction word at pc, combinational read
//   pc          current PC, addresses the instruction memory
//   inst        current instruction register
//   opcode, func3, func7, rd, rs1, rs2   slices of inst
//   bubble      inst holds an inserted NOP rather than a fetched word
//   ill_inst    last load saw a word whose low bits were not 2'b11
//   instret     retired non-bubble instruction count (wraps)
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  pc_sel,
  input  logic [1:0]  inst_sel,
  input  logic [31:0] alu_out,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic [4:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        bubble,
  output logic        ill_inst,
  output logic [31:0] instret
);

  localparam logic [1:0] PC_P4  = 2'd0;
  localparam logic [1:0] PC_M4  = 2'd1;
  localparam logic [1:0] PC_ALU = 2'd2;
  localparam logic [1:0] PC_OLD = 2'd3;

  localparam logic [1:0] INST_MEM = 2'd0;
  localparam logic [1:0] INST_NOP = 2'd1;

  logic [31:0] pc_reg,      pc_next;
  logic [31:0] inst_reg,    inst_next;
  logic        bubble_reg,  bubble_next;
  logic        ill_reg,     ill_next;
  logic [31:0] instret_reg, instret_next;

  // Only a real load (memory or NOP) replaces the instruction; codes 2 and 3
  // both keep the register as-is.
  logic ir_replaced;
  logic mem_word_legal;

  assign ir_replaced    = (inst_sel == INST_MEM) || (inst_sel == INST_NOP);
  assign mem_word_legal = (imem_rdata[1:0] == 2'b11);

  // Next-state logic. Defaults hold every register, so a stall simply
  // skips the update branches below.
  always_comb begin
    pc_next      = pc_reg;
    inst_next    = inst_reg;
    bubble_next  = bubble_reg;
    ill_next     = ill_reg;
    instret_next = instret_reg;

    if (!stall) begin
      // PC arithmetic is plain 32-bit and wraps naturally.
      unique case (pc_sel)
        PC_P4:   pc_next = pc_reg + 32'd4;
        PC_M4:   pc_next = pc_reg - 32'd4;
        PC_ALU:  pc_next = {alu_out[31:1], 1'b0};
        PC_OLD:  pc_next = pc_reg;
        default: pc_next = pc_reg;
      endcase

      case (inst_sel)
        INST_MEM: begin
          if (mem_word_legal) begin
            inst_next   = imem_rdata;
            bubble_next = 1'b0;
            ill_next    = 1'b0;
          end else begin
            // Non-32-bit encodings are replaced by a bubble and flagged.
            inst_next   = NOP_INST;
            bubble_next = 1'b1;
            ill_next    = 1'b1;
          end
        end
        INST_NOP: begin
          inst_next   = NOP_INST;
          bubble_next = 1'b1;
          ill_next    = 1'b0;
        end
        default: begin
          inst_next   = inst_reg;
          bubble_next = bubble_reg;
          ill_next    = ill_reg;
        end
      endcase

      // The instruction currently in the IR retires when it is replaced,
      // so a held instruction is counted exactly once. Uses the pre-edge
      // bubble flag, i.e. describes the outgoing instruction.
      if (ir_replaced && !bubble_reg) begin
        instret_next = instret_reg + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg      <= RESET_PC;
      inst_reg    <= NOP_INST;
      bubble_reg  <= 1'b1;
      ill_reg     <= 1'b0;
      instret_reg <= 32'd0;
    end else begin
      pc_reg      <= pc_next;
      inst_reg    <= inst_next;
      bubble_reg  <= bubble_next;
      ill_reg     <= ill_next;
      instret_reg <= instret_next;
    end
  end

  assign pc       = pc_reg;
  assign inst     = inst_reg;
  assign bubble   = bubble_reg;
  assign ill_inst = ill_reg;
  assign instret  = instret_reg;

  // Decoded fields: direct slices, no added latency.
  assign opcode = inst_reg[6:2];
  assign rd     = inst_reg[11:7];
  assign func3  = inst_reg[14:12];
  assign rs1    = inst_reg[19:15];
  assign rs2    = inst_reg[24:20];
  assign func7  = inst_reg[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [1:0]  pc_sel;
  logic [1:0]  inst_sel;
  logic [31:0] alu_out;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [4:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        bubble;
  logic        ill_inst;
  logic [31:0] instret;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .pc_sel     (pc_sel),
    .inst_sel   (inst_sel),
    .alu_out    (alu_out),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .inst       (inst),
    .opcode     (opcode),
    .func3      (func3),
    .func7      (func7),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .bubble     (bubble),
    .ill_inst   (ill_inst),
    .instret    (instret)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic [1:0]  pc_sel;
    logic [1:0]  inst_sel;
    logic [31:0] alu_out;
    logic [31:0] imem;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_bubble;
    logic        e_ill;
    logic [31:0] e_instret;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic r, input logic s, input logic [1:0] ps,
                              input logic [1:0] is, input logic [31:0] alu,
                              input logic [31:0] im, input logic [31:0] epc,
                              input logic [31:0] einst, input logic eb,
                              input logic eill, input logic [31:0] eir);
    vec_t v;
    v.rst = r; v.stall = s; v.pc_sel = ps; v.inst_sel = is;
    v.alu_out = alu; v.imem = im;
    v.e_pc = epc; v.e_inst = einst; v.e_bubble = eb; v.e_ill = eill;
    v.e_instret = eir;
    return v;
  endfunction

  // Apply inputs away from the edge, take one posedge, sample on negedge.
  task automatic step(input logic r, input logic s, input logic [1:0] ps,
                      input logic [1:0] is, input logic [31:0] alu,
                      input logic [31:0] im);
    rst = r; stall = s; pc_sel = ps; inst_sel = is; alu_out = alu; imem_rdata = im;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] epc,
                       input logic [31:0] einst, input logic eb,
                       input logic eill, input logic [31:0] eir);
    logic [29:0] got_f, exp_f;
    got_f = {func7, rs2, rs1, func3, rd, opcode};
    exp_f = {einst[31:25], einst[24:20], einst[19:15], einst[14:12], einst[11:7], einst[6:2]};
    total += 6;
    if (pc !== epc) begin
      bad++; $display("FAIL %s pc got=%08h exp=%08h", name, pc, epc);
    end
    if (inst !== einst) begin
      bad++; $display("FAIL %s inst got=%08h exp=%08h", name, inst, einst);
    end
    if (bubble !== eb) begin
      bad++; $display("FAIL %s bubble got=%0b exp=%0b", name, bubble, eb);
    end
    if (ill_inst !== eill) begin
      bad++; $display("FAIL %s ill_inst got=%0b exp=%0b", name, ill_inst, eill);
    end
    if (instret !== eir) begin
      bad++; $display("FAIL %s instret got=%0d exp=%0d", name, instret, eir);
    end
    if (got_f !== exp_f) begin
      bad++; $display("FAIL %s fields got=%08h exp=%08h", name, got_f, exp_f);
    end
    $display("%s pc=%08h inst=%08h bubble=%0b ill=%0b instret=%0d",
             name, pc, inst, bubble, ill_inst, instret);
  endtask

  initial begin
    //                 rst  stl  pc_sel inst_sel alu          imem           e_pc          e_inst        b  ill instret
    vecs[0]  = mk(1'b1, 1'b0, 2'd0, 2'd0, 32'h0,        32'h0,        32'h0000_0000, 32'h0000_0013, 1, 0, 0);
    vecs[1]  = mk(1'b0, 1'b0, 2'd0, 2'd0, 32'h0,        32'h0050_0093, 32'h0000_0004, 32'h0050_0093, 0, 0, 0);
    vecs[2]  = mk(1'b0, 1'b0, 2'd0, 2'd0, 32'h0,        32'h00A0_0113, 32'h0000_0008, 32'h00A0_0113, 0, 0, 1);
    vecs[3]  = mk(1'b0, 1'b0, 2'd0, 2'd0, 32'h0,        32'h0020_81B3, 32'h0000_000C, 32'h0020_81B3, 0, 0, 2);
    // jump with bubble insertion; alu bit 0 is dropped
    vecs[4]  = mk(1'b0, 1'b0, 2'd2, 2'd1, 32'h0000_0101, 32'h0,        32'h0000_0100, 32'h0000_0013, 1, 0, 3);
    // bubble leaving the IR does not count
    vecs[5]  = mk(1'b0, 1'b0, 2'd0, 2'd0, 32'h0,        32'h0000_0013, 32'h0000_0104, 32'h0000_0013, 0, 0, 3);
    vecs[6]  = mk(1'b0, 1'b0, 2'd2, 2'd2, 32'h0000_0015, 32'h0,        32'h0000_0014, 32'h0000_0013, 0, 0, 3);
    // load sequence from pc=20: M4/OLD then P4/NOP
    vecs[7]  = mk(1'b0, 1'b0, 2'd1, 2'd2, 32'h0,        32'hDEAD_BEEF, 32'h0000_0010, 32'h0000_0013, 0, 0, 3);
    vecs[8]  = mk(1'b0, 1'b0, 2'd0, 2'd1, 32'h0,        32'h0,        32'h0000_0014, 32'h0000_0013, 1, 0, 4);
    // PC_OLD + INST_MEM refetch
    vecs[9]  = mk(1'b0, 1'b0, 2'd3, 2'd0, 32'h0,        32'h00B0_0193, 32'h0000_0014, 32'h00B0_0193, 0, 0, 4);
    // reserved inst_sel=3 behaves like hold, no count
    vecs[10] = mk(1'b0, 1'b0, 2'd0, 2'd3, 32'h0,        32'hDEAD_BEEF, 32'h0000_0018, 32'h00B0_0193, 0, 0, 4);
    // illegal word
    vecs[11] = mk(1'b0, 1'b0, 2'd0, 2'd0, 32'h0,        32'hFFFF_FFFC, 32'h0000_001C, 32'h0000_0013, 1, 1, 5);
    // ill_inst holds through INST_OLD
    vecs[12] = mk(1'b0, 1'b0, 2'd0, 2'd2, 32'h0,        32'h0,        32'h0000_0020, 32'h0000_0013, 1, 1, 5);
    // next load clears it
    vecs[13] = mk(1'b0, 1'b0, 2'd0, 2'd0, 32'h0,        32'h0000_0033, 32'h0000_0024, 32'h0000_0033, 0, 0, 5);
    vecs[14] = mk(1'b0, 1'b0, 2'd2, 2'd1, 32'hFFFF_FFFD, 32'h0,        32'hFFFF_FFFC, 32'h0000_0013, 1, 0, 6);
    // wrap up: FFFFFFFC + 4 = 0
    vecs[15] = mk(1'b0, 1'b0, 2'd0, 2'd0, 32'h0,        32'h0000_0013, 32'h0000_0000, 32'h0000_0013, 0, 0, 6);
    // wrap down: 0 - 4 = FFFFFFFC
    vecs[16] = mk(1'b0, 1'b0, 2'd1, 2'd0, 32'h0,        32'h0020_8033, 32'hFFFF_FFFC, 32'h0020_8033, 0, 0, 7);
    vecs[17] = mk(1'b0, 1'b0, 2'd0, 2'd0, 32'h0,        32'h0000_0093, 32'h0000_0000, 32'h0000_0093, 0, 0, 8);

    rst = 1'b1; stall = 1'b0; pc_sel = 2'd0; inst_sel = 2'd0;
    alu_out = 32'h0; imem_rdata = 32'h0;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].rst, vecs[i].stall, vecs[i].pc_sel, vecs[i].inst_sel,
           vecs[i].alu_out, vecs[i].imem);
      check($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_inst,
            vecs[i].e_bubble, vecs[i].e_ill, vecs[i].e_instret);
    end

    // Two stalled cycles with a pending jump: nothing moves.
    step(1'b0, 1'b1, 2'd2, 2'd0, 32'h0000_0040, 32'h0000_0013);
    check("stall1", 32'h0, 32'h0000_0093, 1'b0, 1'b0, 32'd8);
    step(1'b0, 1'b1, 2'd2, 2'd0, 32'h0000_0040, 32'hFFFF_FFFC);
    check("stall2", 32'h0, 32'h0000_0093, 1'b0, 1'b0, 32'd8);
    // Release: jump takes effect.
    step(1'b0, 1'b0, 2'd2, 2'd0, 32'h0000_0040, 32'h0000_0013);
    check("unstall", 32'h0000_0040, 32'h0000_0013, 1'b0, 1'b0, 32'd9);
    // Illegal all-zero word sets ill_inst.
    step(1'b0, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0000_0000);
    check("ill_zero", 32'h0000_0044, 32'h0000_0013, 1'b1, 1'b1, 32'd10);
    // Reset together with stall: reset wins.
    step(1'b1, 1'b1, 2'd2, 2'd0, 32'h0000_0080, 32'h0000_0093);
    check("rst_stall", 32'h0, 32'h0000_0013, 1'b1, 1'b0, 32'd0);
    // Resume after reset.
    step(1'b0, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0050_0093);
    check("post_rst", 32'h0000_0004, 32'h0050_0093, 1'b0, 1'b0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
